// File: rtl/rv32_f_fetch_buffer.sv
// ============================================================================
// rv32_f_fetch_buffer
//
// Purpose:
//   A small circular FIFO that sits between the fetch and decode stages of an
//   RV32 pipeline. It holds up to DEPTH fetched {instruction, pc} pairs. The
//   head entry goes to decode together with its pc + 4. A redirect (flush)
//   discards all contents in one cycle.
//
// Parameters:
//   DEPTH  number of entries (2, 4 or 8)
//   XLEN   width of the pc and instruction fields
//
// Optional feature (compile-time macro):
//   FETCH_BYPASS_EN  If the buffer is empty, an incoming instruction goes
//                    straight through to decode in the same cycle. If decode
//                    accepts it, it is never stored. If this macro is not
//                    defined, there is no combinational path from in_* to
//                    out_*. In that case the push-to-valid latency is one
//                    cycle.
//
// Ports:
//   clk_i           clock, rising edge active
//   rst_ni          asynchronous active-low reset
//   in_valid_i      fetch presents an instruction
//   in_instr_i      fetched instruction word
//   in_pc_i         pc of the fetched instruction
//   in_ready_o      buffer accepts this cycle (not full)
//   out_valid_o     head entry valid for decode
//   out_instr_o     head instruction (0 when out_valid_o is low)
//   out_pc_o        head pc (0 when out_valid_o is low)
//   out_pc_plus4_o  out_pc_o + 4, wrapping at XLEN bits
//   out_ready_i     decode consumes the head; low means decode stall
//   flush_i         branch/jump redirect; clears the buffer
//   count_o         number of occupied entries
// ============================================================================
module rv32_f_fetch_buffer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid_i,
    input  logic [XLEN-1:0]          in_instr_i,
    input  logic [XLEN-1:0]          in_pc_i,
    output logic                     in_ready_o,
    output logic                     out_valid_o,
    output logic [XLEN-1:0]          out_instr_o,
    output logic [XLEN-1:0]          out_pc_o,
    output logic [XLEN-1:0]          out_pc_plus4_o,
    input  logic                     out_ready_i,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Storage. It is not reset: the output muxing forces idle values
    // whenever the buffer is empty.
    logic [XLEN-1:0]  r_instr_mem [DEPTH];
    logic [XLEN-1:0]  r_pc_mem    [DEPTH];

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_bypass_taken;
    logic             w_head_valid;
    logic [XLEN-1:0]  w_head_instr;
    logic [XLEN-1:0]  w_head_pc;
    logic [XLEN-1:0]  w_out_pc;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // in_ready_o depends only on the registered count. A same-cycle pop
    // does not open a full buffer, and a flush does not change it either.
    assign in_ready_o = ~w_full;

`ifdef FETCH_BYPASS_EN
    logic w_bypass;
    // Bypass is offered only when nothing is stored. This keeps program
    // order intact.
    assign w_bypass       = w_empty & in_valid_i & ~flush_i;
    assign w_bypass_taken = w_bypass & out_ready_i;
`else
    assign w_bypass_taken = 1'b0;
`endif

    // A flush overrides both push and pop. A bypassed instruction that
    // decode accepted does not occupy a slot.
    assign w_push = in_valid_i & ~w_full & ~flush_i & ~w_bypass_taken;
    // A pop only ever consumes a stored entry. The bypass case is handled
    // entirely by w_bypass_taken.
    assign w_pop  = ~w_empty & out_ready_i & ~flush_i;

    // Head selection.
    always_comb begin
        w_head_valid = ~w_empty;
        w_head_instr = r_instr_mem[r_rd_ptr];
        w_head_pc    = r_pc_mem[r_rd_ptr];
`ifdef FETCH_BYPASS_EN
        if (w_bypass) begin
            w_head_valid = 1'b1;
            w_head_instr = in_instr_i;
            w_head_pc    = in_pc_i;
        end
`endif
    end

    // An idle head reads as instruction 0 at pc 0. Downstream decodes
    // opcode 0 as a no-op.
    assign w_out_pc       = w_head_valid ? w_head_pc : '0;
    assign out_valid_o    = w_head_valid;
    assign out_instr_o    = w_head_valid ? w_head_instr : '0;
    assign out_pc_o       = w_out_pc;
    assign out_pc_plus4_o = w_out_pc + XLEN'(4);
    assign count_o        = r_count;

    // Storage write port.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= in_instr_i;
            r_pc_mem[r_wr_ptr]    <= in_pc_i;
        end
    end

    // Pointers and occupancy. DEPTH is a power of two, so the pointers
    // wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_f_fetch_buffer.sv
module tb_rv32_f_fetch_buffer;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic              clk_i;
    logic              rst_ni;
    logic              in_valid_i;
    logic [XLEN-1:0]   in_instr_i;
    logic [XLEN-1:0]   in_pc_i;
    logic              in_ready_o;
    logic              out_valid_o;
    logic [XLEN-1:0]   out_instr_o;
    logic [XLEN-1:0]   out_pc_o;
    logic [XLEN-1:0]   out_pc_plus4_o;
    logic              out_ready_i;
    logic              flush_i;
    logic [2:0]        count_o;

    rv32_f_fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .in_valid_i     (in_valid_i),
        .in_instr_i     (in_instr_i),
        .in_pc_i        (in_pc_i),
        .in_ready_o     (in_ready_o),
        .out_valid_o    (out_valid_o),
        .out_instr_o    (out_instr_o),
        .out_pc_o       (out_pc_o),
        .out_pc_plus4_o (out_pc_plus4_o),
        .out_ready_i    (out_ready_i),
        .flush_i        (flush_i),
        .count_o        (count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   m_count;
    int   n_checks;
    int   n_fail;
    bit   mon_en;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        in_valid_i  = 1'b0;
        in_pc_i     = '0;
        in_instr_i  = '0;
        out_ready_i = 1'b0;
        flush_i     = 1'b0;
    endtask

    // Drives one cycle of stimulus. Entered just after a rising edge.
    // Expected entries are queued here; the monitor checks them.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic rdy, input logic fl);
        bit push_ok;
        bit pop_ok;
        bit byp;
        in_valid_i  = v;
        in_pc_i     = pc;
        in_instr_i  = ins;
        out_ready_i = rdy;
        flush_i     = fl;
        byp = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp = v && !fl && (m_count == 0);
`endif
        push_ok = v && (m_count < DEPTH) && !fl;
        pop_ok  = !fl && rdy && ((m_count != 0) || byp);
        if (push_ok) exp_q.push_back('{pc: pc, instr: ins});
        $display("cycle t=%0t v=%0b pc=0x%08h rdy=%0b flush=%0b push=%0b pop=%0b",
                 $time, v, pc, rdy, fl, push_ok, pop_ok);
        @(posedge clk_i);
        #1;
        if (fl) begin
            exp_q.delete();
            m_count = 0;
        end else begin
            m_count = m_count + int'(push_ok) - int'(pop_ok);
        end
    endtask

    // Monitor: on every falling edge, check the status and the head entry.
    initial begin
        bit   exp_v;
        exp_t h;
        forever begin
            @(negedge clk_i);
            if (mon_en && rst_ni) begin
                exp_v = (m_count != 0);
`ifdef FETCH_BYPASS_EN
                if (m_count == 0 && in_valid_i && !flush_i) exp_v = 1'b1;
`endif
                chk("count", 64'(count_o), 64'(m_count));
                chk("in_ready", 64'(in_ready_o), 64'(m_count < DEPTH));
                chk("out_valid", 64'(out_valid_o), 64'(exp_v));
                if (out_valid_o) begin
                    if (exp_q.size() == 0) begin
                        chk("head_unexpected", 64'(out_pc_o), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        h = exp_q[0];
                        chk("head_pc", 64'(out_pc_o), 64'(h.pc));
                        chk("head_instr", 64'(out_instr_o), 64'(h.instr));
                        chk("head_pc4", 64'(out_pc_plus4_o), 64'(32'(h.pc + 32'd4)));
                        if (out_ready_i && !flush_i) begin
                            void'(exp_q.pop_front());
                            $display("pop pc=0x%08h instr=0x%08h", h.pc, h.instr);
                        end
                    end
                end else begin
                    chk("idle_instr", 64'(out_instr_o), 64'h0);
                    chk("idle_pc", 64'(out_pc_o), 64'h0);
                    chk("idle_pc4", 64'(out_pc_plus4_o), 64'h4);
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_count  = 0;
        mon_en   = 1'b0;
        set_idle();
        rst_ni = 1'b0;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_count", 64'(count_o), 64'h0);
        chk("rst_in_ready", 64'(in_ready_o), 64'h1);
        chk("rst_out_valid", 64'(out_valid_o), 64'h0);
        chk("rst_instr", 64'(out_instr_o), 64'h0);
        chk("rst_pc4", 64'(out_pc_plus4_o), 64'h4);

        // Fetch is already active while reset is released. The first edge
        // with reset high must accept the push.
        in_valid_i = 1'b1;
        in_pc_i    = 32'h100;
        in_instr_i = 32'h0050_0093;
        exp_q.push_back('{pc: 32'h100, instr: 32'h0050_0093});
        @(negedge clk_i);
        #1 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        m_count = 1;
        mon_en  = 1'b1;
        chk("first_push_count", 64'(count_o), 64'h1);

        // Fill to four entries; the fifth push is ignored
        cycle(1'b1, 32'h104, 32'h00A0_0113, 1'b0, 1'b0);
        cycle(1'b1, 32'h108, 32'h00F0_0193, 1'b0, 1'b0);
        cycle(1'b1, 32'h10C, 32'h0140_0213, 1'b0, 1'b0);
        cycle(1'b1, 32'h110, 32'h0190_0293, 1'b0, 1'b0);
        chk("full_count", 64'(count_o), 64'h4);
        chk("full_in_ready", 64'(in_ready_o), 64'h0);
        chk("full_head_pc", 64'(out_pc_o), 64'h100);

        // Full: push and pop in the same cycle -> only the pop happens
        cycle(1'b1, 32'h114, 32'h01E0_0313, 1'b1, 1'b0);
        chk("after_full_pop_count", 64'(count_o), 64'h3);
        chk("after_full_pop_ready", 64'(in_ready_o), 64'h1);

        // Reach count 2, then push and pop together across the pointer wrap
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 32'h300 + 32'(4 * i), 32'h0000_0013 | (32'(i) << 20), 1'b1, 1'b0);
        end
        chk("steady_count", 64'(count_o), 64'h2);

        // count 3, then flush while pushing and popping
        cycle(1'b1, 32'h400, 32'h0000_0513, 1'b0, 1'b0);
        chk("pre_flush_count", 64'(count_o), 64'h3);
        cycle(1'b1, 32'h404, 32'h0000_0593, 1'b1, 1'b1);
        set_idle();
        #1;
        chk("flush_count", 64'(count_o), 64'h0);
        chk("flush_valid", 64'(out_valid_o), 64'h0);
        chk("flush_instr", 64'(out_instr_o), 64'h0);

        // pc + 4 wraps at 32 bits
        cycle(1'b1, 32'hFFFF_FFFC, 32'h0000_0073, 1'b0, 1'b0);
        set_idle();
        #1;
        chk("wrap_pc", 64'(out_pc_o), 64'hFFFF_FFFC);
        chk("wrap_pc4", 64'(out_pc_plus4_o), 64'h0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Push into an empty buffer while decode is ready
        cycle(1'b1, 32'h200, 32'h0010_0093, 1'b1, 1'b0);
`ifdef FETCH_BYPASS_EN
        chk("bypass_count", 64'(count_o), 64'h0);
`else
        chk("nobypass_count", 64'(count_o), 64'h1);
        chk("nobypass_valid", 64'(out_valid_o), 64'h1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
`endif

        repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("drained_queue", 64'(exp_q.size()), 64'h0);
        chk("final_count", 64'(count_o), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32_f_fetch_buffer.md
RV32_F_FETCH_BUFFER -- requirements
Module: rv32_f_fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of instruction entries; legal values 2, 4 or 8.
REQ-002 SHALL have parameter XLEN, default 32, width of pc and instruction fields.
REQ-003 SHALL have port clk_i, input, 1, the single clock, rising-edge active.
REQ-004 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid_i, input, 1, fetch stage presents an instruction.
REQ-006 SHALL have port in_instr_i, input, XLEN, fetched instruction word.
REQ-007 SHALL have port in_pc_i, input, XLEN, pc of the fetched instruction.
REQ-008 SHALL have port in_ready_o, output, 1, buffer accepts this cycle.
REQ-009 SHALL have port out_valid_o, output, 1, head entry valid for decode.
REQ-010 SHALL have port out_instr_o, output, XLEN, head instruction.
REQ-011 SHALL have port out_pc_o, output, XLEN, head pc.
REQ-012 SHALL have port out_pc_plus4_o, output, XLEN, head pc + 4.
REQ-013 SHALL have port out_ready_i, input, 1, decode consumes the head; low means decode stall.
REQ-014 SHALL have port flush_i, input, 1, branch/jump redirect; discards all contents.
REQ-015 SHALL have port count_o, output, log2(DEPTH)+1, occupied entries.

Function
REQ-016 SHALL implement a circular FIFO with read pointer, write pointer and occupancy counter; pointers wrap modulo DEPTH.
REQ-017 SHALL push when in_valid_i and in_ready_o are both high at a rising edge; SHALL pop when out_valid_o and out_ready_i are both high.
REQ-018 SHALL drive in_ready_o = (count_o < DEPTH); a pop in the same cycle SHALL NOT make a full buffer ready.
REQ-019 SHALL support simultaneous push and pop when neither full nor empty; count_o is unchanged and both pointers advance.
REQ-020 SHALL drive out_valid_o = (count_o != 0) when FETCH_BYPASS_EN is undefined; the latency from push to out_valid_o is 1 cycle.
REQ-021 SHALL drive out_instr_o = 32'h0000_0000, out_pc_o = 0 and out_pc_plus4_o = 4 when out_valid_o is low; opcode 0 decodes as a control no-op downstream.
REQ-022 SHALL compute out_pc_plus4_o = out_pc_o + 4, truncated to XLEN bits, so 0xFFFF_FFFC wraps to 0x0000_0000.
REQ-023 SHALL, on flush_i high at a rising edge, set both pointers and count_o to 0; any push or pop in that cycle is discarded.
REQ-024 SHALL keep in_ready_o unaffected by flush_i combinationally; the flush has priority over the push.
REQ-025 SHALL, while the buffer is empty, ignore out_ready_i; while full, ignore in_valid_i.
REQ-026 SHALL hold the head outputs stable while out_valid_o is high and out_ready_i is low.

Reset
REQ-027 SHALL, while rst_ni is low, asynchronously clear the pointers and count_o to 0; out_valid_o SHALL be 0 and in_ready_o SHALL be 1.
REQ-028 SHALL NOT reset the storage array; out_* data SHALL still read as the REQ-021 values because out_valid_o is low.
REQ-029 SHALL, on deassertion of reset during active fetch, accept the first push on the first rising edge with rst_ni high.

Configuration
REQ-030 SHALL, when macro FETCH_BYPASS_EN is defined, pass in_* combinationally to out_* with out_valid_o = 1 when the buffer is empty, in_valid_i = 1 and flush_i = 0. If out_ready_i is also high, the entry SHALL NOT be stored and count_o SHALL stay 0.
REQ-031 SHALL, when FETCH_BYPASS_EN is defined and the bypass is offered but out_ready_i is low, store the entry normally.
REQ-032 SHALL, without FETCH_BYPASS_EN, have no combinational path from in_* to out_*.

Verification
REQ-033 Push pc 0x100..0x10C (instr 0x00500093...) with out_ready_i=0 -> count_o=4, in_ready_o=0; the fifth push is ignored; the head is pc 0x100.
REQ-034 Buffer full, out_ready_i=1 and in_valid_i=1 for one cycle -> only the pop occurs; count_o=3; in_ready_o=1 the next cycle.
REQ-035 count=2, push and pop together for 10 cycles -> count_o remains 2; pcs exit in order across pointer wrap.
REQ-036 count=3, flush_i=1 with in_valid_i=1 -> next cycle count_o=0, out_valid_o=0, out_instr_o=0x00000000.
REQ-037 Head pc 0xFFFF_FFFC -> out_pc_plus4_o=0x0000_0000.
REQ-038 FETCH_BYPASS_EN defined, empty, in_valid_i=1 with pc 0x200, out_ready_i=1 -> out_valid_o=1 and out_pc_o=0x200 in the same cycle; count_o stays 0. Without the macro -> out_valid_o rises the next cycle.
